// File: rtl/result_bus_arbiter.sv
// Result bus arbiter: round-robin grant of one execution-unit result per cycle onto the shared broadcast bus.
// Latency: 1 cycle from grant to out_valid (2 cycles from req_valid when RESULT_ARB_SKID_EN is defined).
// Backpressure: req_ready is withheld from losing requesters and during flush/reset; no downstream backpressure.
//
// Ports:
//   clk, nrst            clock, synchronous active-low reset
//   flush                branch-miss flush: blocks grants/transfers this cycle, clears skid entries
//   req_valid/req_data   per-requester result word, requester i at req_data[i*RESULT_W +: RESULT_W]
//   req_ready            per-requester acceptance (transfer = req_valid & req_ready at clk edge)
//   out_valid/out_data   registered one-cycle broadcast pulse and the granted Result word
//   out_src              index of the requester that produced out_data
//
// Optional feature macro: RESULT_ARB_SKID_EN (one-entry skid register per requester;
// arbitration then runs on skid contents and req_ready no longer depends on other requesters).
//
// Result word layout: commit_id[49:42], en[41], kind[40], content[39:0].

module result_bus_arbiter #(
   parameter int NREQ     = 4,
   parameter int RESULT_W = 50
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     flush,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*RESULT_W-1:0] req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     out_valid,
   output logic [RESULT_W-1:0]      out_data,
   output logic [2:0]               out_src
);

   // Position of the 'en' flag inside a Result word.
   localparam int EN_BIT = 41;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [2:0]          rr_ptr_q,    rr_ptr_d;
   logic                out_valid_q, out_valid_d;
   logic [RESULT_W-1:0] out_data_q,  out_data_d;
   logic [2:0]          out_src_q,   out_src_d;

   // ------------------------------------------------------------------
   // Unpack the flat request bus into per-requester words and en flags
   // ------------------------------------------------------------------
   logic [RESULT_W-1:0] in_word [NREQ];
   logic [NREQ-1:0]     in_en;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         in_word[i] = req_data[i*RESULT_W +: RESULT_W];
         in_en[i]   = req_data[i*RESULT_W + EN_BIT];
      end
   end

   // Arbitration inputs: which entries compete and the word each would broadcast.
   logic [NREQ-1:0]     cand;
   logic [RESULT_W-1:0] arb_word [NREQ];

   // Grant results
   logic                gnt_vld;
   logic [2:0]          gnt_idx;
   logic [NREQ-1:0]     gnt_oh;
   logic [RESULT_W-1:0] gnt_word;

   // Flush or reset suppresses every grant and every transfer in the cycle.
   logic                allow;
   assign allow = nrst & ~flush;

`ifdef RESULT_ARB_SKID_EN
   // ------------------------------------------------------------------
   // Skid mode: each requester parks one enabled result in its own
   // register; the arbiter only ever looks at parked entries.
   // ------------------------------------------------------------------
   logic [NREQ-1:0]     skid_vld_q, skid_vld_d;
   logic [RESULT_W-1:0] skid_dat_q [NREQ];
   logic [RESULT_W-1:0] skid_dat_d [NREQ];

   always_comb begin
      cand = skid_vld_q;
      for (int i = 0; i < NREQ; i++) begin
         arb_word[i] = skid_dat_q[i];
      end
   end

   // Ready depends only on this requester's own skid slot: empty now, or
   // emptying at this edge because it wins the bus.
   always_comb begin
      req_ready = (~skid_vld_q | gnt_oh) & {NREQ{allow}};
   end

   // A transfer with en=0 is accepted and simply not parked.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         skid_vld_d[i] = skid_vld_q[i];
         skid_dat_d[i] = skid_dat_q[i];
         if (gnt_oh[i]) begin
            skid_vld_d[i] = 1'b0;
         end
         if (req_valid[i] && req_ready[i] && in_en[i]) begin
            skid_vld_d[i] = 1'b1;
            skid_dat_d[i] = in_word[i];
         end
         if (flush) begin
            skid_vld_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         skid_vld_q <= '0;
         for (int i = 0; i < NREQ; i++) begin
            skid_dat_q[i] <= '0;
         end
      end else begin
         skid_vld_q <= skid_vld_d;
         for (int i = 0; i < NREQ; i++) begin
            skid_dat_q[i] <= skid_dat_d[i];
         end
      end
   end
`else
   // ------------------------------------------------------------------
   // Direct mode: arbitrate straight off the request inputs.
   // ------------------------------------------------------------------
   always_comb begin
      cand = req_valid & in_en;
      for (int i = 0; i < NREQ; i++) begin
         arb_word[i] = in_word[i];
      end
   end

   // en=0 results are sunk immediately and never compete for the bus.
   always_comb begin
      req_ready = (gnt_oh | (req_valid & ~in_en)) & {NREQ{allow}};
   end
`endif

   // ------------------------------------------------------------------
   // Round-robin search: walk candidates starting at rr_ptr_q, wrapping
   // NREQ-1 -> 0; the first hit wins.
   // ------------------------------------------------------------------
   always_comb begin
      int  pos;
      logic hit;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      pos     = 0;
      hit     = 1'b0;
      if (allow) begin
         for (int k = 0; k < NREQ; k++) begin
            pos = int'(rr_ptr_q) + k;
            if (pos >= NREQ) begin
               pos = pos - NREQ;
            end
            hit = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
               if (i == pos) begin
                  hit = cand[i];
               end
            end
            if (!gnt_vld && hit) begin
               gnt_vld = 1'b1;
               gnt_idx = 3'(pos);
            end
         end
      end
   end

   // One-hot form of the grant and the selected word.
   always_comb begin
      gnt_oh   = '0;
      gnt_word = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_vld && (gnt_idx == 3'(i))) begin
            gnt_oh[i] = 1'b1;
            gnt_word  = arb_word[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state: pointer advances past the winner; broadcast registers
   // load on a grant, otherwise out_data/out_src keep their last value.
   // ------------------------------------------------------------------
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = gnt_vld;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (gnt_vld) begin
         out_data_d = gnt_word;
         out_src_d  = gnt_idx;
         if (gnt_idx == 3'(NREQ-1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gnt_idx + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule
